// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory stage.
package dmem_pkg;

    // Access width encoding; SZ_BAD is always rejected.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int DEPTH_DEF = 256;
    localparam int WAIT_DEF  = 2;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for the data memory: store merge, load extract/extend,
// and alignment checking. Purely combinational.
module dmem_lane
    import dmem_pkg::*;
#(
    parameter int N = 32
) (
    input  size_t          size,
    input  logic           sign_ext,
    input  logic [1:0]     lane,
    input  logic [N-1:0]   old_word,
    input  logic [N-1:0]   wdata,
    output logic [N-1:0]   merged,
    output logic [N-1:0]   load_val,
    output logic           misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection, store merge and load extension for the current size.
    always_comb begin
        merged   = old_word;
        load_val = '0;
        misalign = 1'b0;
        byte_sel = old_word[{lane, 3'b000} +: 8];
        half_sel = old_word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                load_val = {{(N-8){sign_ext & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                misalign = lane[0];
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                load_val = {{(N-16){sign_ext & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                misalign = |lane;
                merged   = wdata;
                load_val = old_word;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage after the ALU: byte/half/word loads and stores to a
// wait-stated memory behind a req/ready/done handshake.
// Optional macro DMEM_STATS_EN adds saturating load/store/error counters.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = DEPTH_DEF,
    parameter int WAIT  = WAIT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    input  logic           we,
    input  logic [1:0]     size,
    input  logic           sign_ext,
    input  logic [N-1:0]   addr,
    input  logic [N-1:0]   wdata,
    output logic           ready,
    output logic           done,
    output logic           err,
    output logic [N-1:0]   rdata
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]    ld_cnt,
    output logic [15:0]    st_cnt,
    output logic [15:0]    err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    state_t         state;
    state_t         nxt;
    logic [3:0]     cnt;
    logic           we_q;
    logic           sext_q;
    size_t          size_q;
    logic [AW+1:0]  addr_q;
    logic [N-1:0]   wdata_q;
    logic [N-1:0]   mem [DEPTH];

    size_t          sel_size;
    logic [1:0]     sel_lane;
    logic [N-1:0]   old_word;
    logic [N-1:0]   merged;
    logic [N-1:0]   load_val;
    logic           misalign;
    logic           accept;
    logic           access;
    logic           unused_addr;

    // Address bits above the memory span wrap and are deliberately ignored.
    assign unused_addr = ^addr[N-1:AW+2];

    // In IDLE the lane logic checks the live request; afterwards it works on
    // the latched request so inputs only need to hold in the accepting cycle.
    assign sel_size = (state == IDLE) ? size_t'(size) : size_q;
    assign sel_lane = (state == IDLE) ? addr[1:0] : addr_q[1:0];
    assign old_word = mem[addr_q[AW+1:2]];
    assign accept   = req && ready;
    assign access   = (state == BUSY) && (cnt == 4'd0);

    dmem_lane #(.N(N)) u_lane (
        .size     (sel_size),
        .sign_ext (sext_q),
        .lane     (sel_lane),
        .old_word (old_word),
        .wdata    (wdata_q),
        .merged   (merged),
        .load_val (load_val),
        .misalign (misalign)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        nxt   = state;
        ready = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) nxt = misalign ? RESP : BUSY;
            end
            BUSY: begin
                if (cnt == 4'd0) nxt = RESP;
            end
            RESP: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Wait counter, error flag and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 4'd0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            if (accept) begin
                err <= misalign;
                cnt <= 4'(WAIT);
            end else if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !we_q) rdata <= load_val;
        end
    end

    // Request fields captured on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            size_q  <= size_t'(size);
            sext_q  <= sign_ext;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
        end
    end

    // Memory write on the access edge of a store.
    always_ff @(posedge clk) begin
        if (access && we_q) mem[addr_q[AW+1:2]] <= merged;
    end

`ifdef DMEM_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Completion counters, bumped once per done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt  <= 16'd0;
            st_cnt  <= 16'd0;
            err_cnt <= 16'd0;
        end else if (state == RESP) begin
            if (err)       err_cnt <= sat_inc(err_cnt);
            else if (we_q) st_cnt  <= sat_inc(st_cnt);
            else           ld_cnt  <= sat_inc(ld_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl (N=32, DEPTH=256, WAIT=2).
module tb_dmem_ctrl;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
        time         tacc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          lat;
    logic [31:0] model_rd = 32'h0;

    dmem_ctrl #(.N(32), .DEPTH(256), .WAIT(WAIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: ready must stay low while a request is outstanding; each done
    // pops one expected response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0) chk("ready_low_busy", {31'b0, ready}, 32'd0);
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1, expected no response (t=%0t)", $time);
                end else begin
                    mon_e = q.pop_front();
                    lat   = int'(($time - 5 - mon_e.tacc) / 10);
                    chk("err", {31'b0, err}, {31'b0, mon_e.err});
                    chk("rdata", rdata, mon_e.rd);
                    chk("latency", lat, mon_e.lat);
                end
            end
        end
    end

    // Present one request for one cycle and queue its expected response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err, input logic [31:0] exp_load);
        exp_t e;
        @(negedge clk);
        chk("ready_idle", {31'b0, ready}, 32'd1);
        req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = d;
        @(posedge clk);
        if (!exp_err && !w) model_rd = exp_load;
        e.err  = exp_err;
        e.rd   = model_rd;
        e.lat  = exp_err ? 0 : WAIT + 1;
        e.tacc = $time;
        q.push_back(e);
        #1;
        req = 1'b0; we = 1'bx; size = 2'bxx; sign_ext = 1'bx; addr = 'x; wdata = 'x;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        issue(1'b1, sz, 1'b0, a, d, exp_err, 32'h0);
        wait_idle();
    endtask

    task automatic ld(input logic [1:0] sz, input logic se, input logic [31:0] a,
                      input logic exp_err, input logic [31:0] exp_val);
        issue(1'b0, sz, se, a, 32'h0, exp_err, exp_val);
        wait_idle();
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        #2 rst_n = 1'b1;

        // 1: word store then word load
        st(2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        ld(2'b10, 1'b0, 32'h10, 1'b0, 32'hDEADBEEF);

        // 2: byte load from lane 3, signed and unsigned
        ld(2'b00, 1'b1, 32'h13, 1'b0, 32'hFFFFFFDE);
        ld(2'b00, 1'b0, 32'h13, 1'b0, 32'h000000DE);

        // 3: half store into upper lanes, word and signed-half loads
        st(2'b01, 32'h12, 32'h00001234, 1'b0);
        ld(2'b10, 1'b0, 32'h10, 1'b0, 32'h1234BEEF);
        ld(2'b01, 1'b1, 32'h10, 1'b0, 32'hFFFFBEEF);

        // 4: misaligned / illegal requests leave rdata and memory alone
        ld(2'b10, 1'b0, 32'h11, 1'b1, 32'h0);
        st(2'b11, 32'h10, 32'hFFFFFFFF, 1'b1);
        ld(2'b01, 1'b0, 32'h13, 1'b1, 32'h0);
        ld(2'b10, 1'b0, 32'h10, 1'b0, 32'h1234BEEF);

        // Byte store preserves neighbouring lanes
        st(2'b10, 32'h20, 32'h11223344, 1'b0);
        st(2'b00, 32'h21, 32'hFFFFFF77, 1'b0);
        ld(2'b10, 1'b0, 32'h20, 1'b0, 32'h11227744);
        ld(2'b01, 1'b0, 32'h22, 1'b0, 32'h00001122);

        // 5: address wrap, and a req pulsed while busy is dropped
        issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5A5A5, 1'b0, 32'h0);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h0;
        @(negedge clk);
        req = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        ld(2'b10, 1'b0, 32'h000, 1'b0, 32'hA5A5A5A5);

        // 6: reset during a store aborts it without a done pulse
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h00000000, 1'b0, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_rdata", rdata, 32'h0);
        q.delete();
        model_rd = 32'h0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ld(2'b10, 1'b0, 32'h10, 1'b0, 32'h1234BEEF);
        ld(2'b10, 1'b0, 32'h000, 1'b0, 32'hA5A5A5A5);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
